// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared op/state encodings and defaults for the multiply/divide unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam int c_default_width = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_sign.sv
// ============================================================================
// Module   : muldiv_sign
// Brief    : Combinational conditional two's-complement negate (abs / sign fix).
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_sign #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (-value) : value;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative MULT/MULTU/DIV/DIVU unit writing results to HI/LO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = c_default_width,
    parameter bit MUL_FAST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] wHiData,
    output logic             whi,
    output logic [WIDTH-1:0] wLoData,
    output logic             wlo
);

    localparam int c_cnt_w = $clog2(WIDTH);
    localparam int c_w2    = 2 * WIDTH;

    state_e               r_state;
    state_e               w_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_m;
    logic [c_w2-1:0]      r_acc;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;

    logic                 w_accept;
    logic                 w_div_req;
    logic                 w_sgn_a;
    logic                 w_sgn_b;
    logic                 w_div_zero;
    logic                 w_fast_mul;
    logic                 w_last;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [c_w2-1:0]      w_fast_prod;
    logic [WIDTH:0]       w_mul_sum;
    logic [c_w2-1:0]      w_mul_next;
    logic [WIDTH:0]       w_rem_sh;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_rem_sub;
    logic [c_w2-1:0]      w_div_next;
    logic [c_w2-1:0]      w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;

    assign w_accept   = (r_state == ST_IDLE) & start_i & ~cancel_i;
    assign w_div_req  = op_is_div(op_i);
    assign w_sgn_a    = op_is_signed(op_i) & a_i[WIDTH-1];
    assign w_sgn_b    = op_is_signed(op_i) & b_i[WIDTH-1];
    assign w_div_zero = w_div_req & (b_i == '0);
    assign w_fast_mul = MUL_FAST & ~w_div_req;
    assign w_last     = (r_cnt == c_cnt_w'(WIDTH - 1));

    muldiv_sign #(.WIDTH(WIDTH)) u_abs_a (.value(a_i), .negate(w_sgn_a), .result(w_abs_a));
    muldiv_sign #(.WIDTH(WIDTH)) u_abs_b (.value(b_i), .negate(w_sgn_b), .result(w_abs_b));

    assign w_fast_prod = {{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b};

    // Shift-add: r_acc = {partial product, remaining multiplier bits}
    assign w_mul_sum  = {1'b0, r_acc[c_w2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: r_acc = {partial remainder, dividend/quotient bits}
    assign w_rem_sh   = {r_acc[c_w2-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge   = (w_rem_sh >= {1'b0, r_m});
    assign w_rem_sub  = w_rem_sh[WIDTH-1:0] - r_m;
    assign w_div_next = {(w_div_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_div_ge};

    muldiv_sign #(.WIDTH(c_w2)) u_fix_prod (.value(r_acc), .negate(r_neg_q), .result(w_prod));
    muldiv_sign #(.WIDTH(WIDTH)) u_fix_quo (.value(r_acc[WIDTH-1:0]), .negate(r_neg_q), .result(w_quo));
    muldiv_sign #(.WIDTH(WIDTH)) u_fix_rem (.value(r_acc[c_w2-1:WIDTH]), .negate(r_neg_r), .result(w_rem));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        busy    = 1'b0;
        whi     = 1'b0;
        wlo     = 1'b0;
        wHiData = '0;
        wLoData = '0;
        stall   = (start_i & ~cancel_i) | (r_state == ST_CALC);
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = (w_div_zero || w_fast_mul) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy   = 1'b1;
                w_next = ST_IDLE;
                // A flushed instruction must not reach HI/LO.
                if (!cancel_i) begin
                    whi     = 1'b1;
                    wlo     = 1'b1;
                    wHiData = r_is_div ? w_rem : w_prod[c_w2-1:WIDTH];
                    wLoData = r_is_div ? w_quo : w_prod[WIDTH-1:0];
                end
            end
            default: w_next = ST_IDLE;
        endcase
        if (cancel_i) begin
            w_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_m      <= '0;
            r_acc    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_is_div <= w_div_req;
            if (w_div_zero) begin
                // Divide by zero bypasses CALC: LO = all ones, HI = raw dividend.
                r_m     <= '0;
                r_acc   <= {a_i, {WIDTH{1'b1}}};
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
            end else begin
                r_m     <= w_div_req ? w_abs_b : w_abs_a;
                r_acc   <= w_fast_mul ? w_fast_prod
                                      : {{WIDTH{1'b0}}, (w_div_req ? w_abs_a : w_abs_b)};
                r_neg_q <= w_sgn_a ^ w_sgn_b;
                r_neg_r <= w_sgn_a;
            end
        end else if (r_state == ST_CALC) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
            r_acc <= r_is_div ? w_div_next : w_mul_next;
        end
    end

endmodule

`default_nettype wire
